// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the multi-port SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W            = 23;
  localparam int DATA_W            = 16;
  localparam int DM_W              = 2;
  localparam int BURST_LEN_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BURST,
    ST_DONE,
    ST_GAP
  } arb_state_e;

  // Bursts are 8-word aligned; the low address bits are forced to zero.
  function automatic logic [ADDR_W-1:0] burst_align(input logic [ADDR_W-1:0] a);
    return a & {{(ADDR_W-3){1'b1}}, 3'b000};
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational picker: port 0 high priority with a fairness cap, ports >=1 round-robin.
module sdram_arb_pick #(
  parameter  int NUM_REQ = 3,
  parameter  int HP_MAX  = 4,
  localparam int PTR_W   = $clog2(NUM_REQ),
  localparam int HP_W    = $clog2(HP_MAX + 1)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr,
  input  logic [HP_W-1:0]    hp_count,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   rr_next
);

  logic             low_req;
  logic             found;
  logic [PTR_W-1:0] sel;
  int unsigned      idx;

  assign low_req = |req[NUM_REQ-1:1];

  always_comb begin
    winner  = '0;
    rr_next = rr;
    found   = 1'b0;
    sel     = '0;
    idx     = 0;
    // Port 0 keeps the bus while under its cap, or when nobody else is asking.
    if (req[0] && ((hp_count < HP_W'(HP_MAX)) || !low_req)) begin
      winner[0] = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ - 1; i++) begin
        idx = 32'(rr) + i;
        if (idx > NUM_REQ - 1) idx = idx - (NUM_REQ - 1);
        sel = PTR_W'(idx);
        if (!found && req[sel]) begin
          found       = 1'b1;
          winner[sel] = 1'b1;
          rr_next     = (idx == NUM_REQ - 1) ? PTR_W'(1) : PTR_W'(idx + 1);
        end
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM driver between NUM_REQ ports, one 8-word burst at a time.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int BURST_LEN  = BURST_LEN_DEFAULT,
  parameter int HP_MAX     = 4,
  parameter int GAP_CYCLES = 3,
  parameter int TIMEOUT    = 63
) (
  input  logic                      memclk_i,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [ADDR_W*NUM_REQ-1:0] addr_i,
  input  logic [DATA_W*NUM_REQ-1:0] wdata_i,
  input  logic [DM_W*NUM_REQ-1:0]   wdm_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        wstrobe_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic                      sd_enable_o,
  output logic                      sd_rd_o,
  output logic                      sd_wr_o,
  output logic [ADDR_W-1:0]         sd_addr_o,
  output logic [DATA_W-1:0]         sd_wdata_o,
  output logic [DM_W-1:0]           sd_dm_o,
  input  logic [DATA_W-1:0]         sd_rdata_i,
  input  logic                      sd_valid_i
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int HP_W  = $clog2(HP_MAX + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  arb_state_e           state, state_next;
  logic [OWN_W-1:0]     owner, rr, rr_next, pick_idx;
  logic [NUM_REQ-1:0]   winner;
  logic                 we_l, tmo, tmo_hit, word_last, active;
  logic [ADDR_W-1:0]    addr_l;
  logic [HP_W-1:0]      hp_cnt;
  logic [TMR_W-1:0]     timer;
  logic [CNT_W-1:0]     word_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];
  logic [DM_W-1:0]   wdm_a   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = wdata_i[g*DATA_W +: DATA_W];
    assign wdm_a[g]   = wdm_i[g*DM_W +: DM_W];
  end

  sdram_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .HP_MAX  (HP_MAX)
  ) u_pick (
    .req      (req_i),
    .rr       (rr),
    .hp_count (hp_cnt),
    .winner   (winner),
    .rr_next  (rr_next)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) pick_idx = OWN_W'(i);
    end
  end

  // timer holds cycles elapsed since ISSUE, so DONE lands TIMEOUT cycles after enable.
  assign tmo_hit   = (timer == TMR_W'(TIMEOUT - 1));
  assign word_last = (word_cnt == CNT_W'(BURST_LEN - 1));
  assign active    = state inside {ST_ISSUE, ST_WAIT, ST_BURST, ST_DONE};

  always_ff @(posedge memclk_i) begin
    if (!reset_n_i) state <= ST_GAP;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (|req_i) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (sd_valid_i)   state_next = (BURST_LEN == 1) ? ST_DONE : ST_BURST;
        else if (tmo_hit) state_next = ST_DONE;
      end
      ST_BURST: if (!sd_valid_i || word_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_GAP;
      ST_GAP:   if (gap_cnt <= GAP_W'(1)) state_next = ST_IDLE;
      default:  state_next = ST_GAP;
    endcase
  end

  always_ff @(posedge memclk_i) begin
    if (!reset_n_i) begin
      owner    <= '0;
      we_l     <= 1'b0;
      addr_l   <= '0;
      rr       <= OWN_W'(1);
      hp_cnt   <= '0;
      timer    <= '0;
      word_cnt <= '0;
      gap_cnt  <= GAP_W'(GAP_CYCLES);
      tmo      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_i) begin
            owner  <= pick_idx;
            we_l   <= we_i[pick_idx];
            addr_l <= burst_align(addr_a[pick_idx]);
            rr     <= rr_next;
            if (winner[0]) hp_cnt <= (hp_cnt < HP_W'(HP_MAX)) ? hp_cnt + 1'b1 : '0;
            else           hp_cnt <= '0;
          end
        end
        ST_ISSUE: begin
          timer    <= TMR_W'(1);
          word_cnt <= '0;
          tmo      <= 1'b0;
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (sd_valid_i)   word_cnt <= CNT_W'(1);
          else if (tmo_hit) tmo      <= 1'b1;
        end
        ST_BURST: if (sd_valid_i) word_cnt <= word_cnt + 1'b1;
        ST_DONE:  gap_cnt <= GAP_W'(GAP_CYCLES);
        ST_GAP:   gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // The first data word arrives while still in WAIT, so WAIT and BURST share the data path.
  always_comb begin
    gnt_o       = '0;
    wstrobe_o   = '0;
    rvalid_o    = '0;
    done_o      = '0;
    err_o       = '0;
    sd_enable_o = 1'b0;
    sd_rd_o     = 1'b0;
    sd_wr_o     = 1'b0;
    sd_addr_o   = '0;
    sd_wdata_o  = '0;
    sd_dm_o     = '0;
    if (active) begin
      gnt_o[owner] = 1'b1;
      sd_wdata_o   = wdata_a[owner];
      sd_dm_o      = wdm_a[owner];
    end
    case (state)
      ST_ISSUE: begin
        sd_enable_o = 1'b1;
        sd_rd_o     = ~we_l;
        sd_wr_o     = we_l;
        sd_addr_o   = addr_l;
      end
      ST_WAIT, ST_BURST: begin
        if (sd_valid_i) begin
          if (we_l) wstrobe_o[owner] = 1'b1;
          else      rvalid_o[owner]  = 1'b1;
        end
      end
      ST_DONE: begin
        done_o[owner] = 1'b1;
        err_o[owner]  = tmo;
      end
      default: ;
    endcase
  end

  assign rdata_o = sd_rdata_i;

endmodule
